// File: rtl/sr_in_reader_if.sv
// Host-side handshake of the input shift-register reader: frame request plus
// the published word, its valid strobe and the busy flag.
interface sr_in_reader_if #(
  parameter int N_BITS = 16
);
  logic              start;
  logic [N_BITS-1:0] data_out;
  logic              valid;
  logic              busy;

  modport master (
    output start,
    input  data_out,
    input  valid,
    input  busy
  );

  modport slave (
    input  start,
    output data_out,
    output valid,
    output busy
  );
endinterface

// File: rtl/sr_in_reader.sv
// Read controller for a 74HC165-style parallel-in/serial-out chain: loads the
// chain, clocks N_BITS out MSB-first and publishes the word with a valid pulse.
module sr_in_reader #(
  parameter int N_BITS     = 16,
  parameter int CLK_DIV    = 4,
  parameter int CONTINUOUS = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_in_reader_if.slave host,
  output logic          SR_STROBE,
  output logic          SR_SCLK,
  input  logic          SR_OUT
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_r;
  logic [PW-1:0]     phase_r;
  logic [BW-1:0]     bit_r;
  logic [N_BITS-1:0] shift_r;
  logic [N_BITS-1:0] data_r;
  logic              valid_r;
  logic              busy_r;

  logic              phase_last_s;
  logic              bit_last_s;
  logic              run_s;
  logic [N_BITS-1:0] shift_next_s;

  // First bit received ends up in the MSB after N_BITS shifts.
  function automatic logic [N_BITS-1:0] shift_in(input logic [N_BITS-1:0] word,
                                                 input logic            b);
    return (word << 1'b1) | N_BITS'(b);
  endfunction

  assign phase_last_s = (phase_r == PW'(CLK_DIV - 1));
  assign bit_last_s   = (bit_r == BW'(N_BITS - 1));
  assign run_s        = host.start || (CONTINUOUS != 0);
  assign shift_next_s = shift_in(shift_r, SR_OUT);

  assign host.data_out = data_r;
  assign host.valid    = valid_r;
  assign host.busy     = busy_r;

  // Frame sequencer; every output is set on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      phase_r   <= {PW{1'b0}};
      bit_r     <= {BW{1'b0}};
      shift_r   <= {N_BITS{1'b0}};
      data_r    <= {N_BITS{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      SR_STROBE <= 1'b1;
      SR_SCLK   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          SR_STROBE <= 1'b1;
          SR_SCLK   <= 1'b0;
          phase_r   <= {PW{1'b0}};
          if (run_s) begin
            state_r   <= ST_LOAD;
            SR_STROBE <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (phase_last_s) begin
            phase_r   <= {PW{1'b0}};
            state_r   <= ST_SETTLE;
            SR_STROBE <= 1'b1;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end

        ST_SETTLE: begin
          if (phase_last_s) begin
            phase_r <= {PW{1'b0}};
            bit_r   <= {BW{1'b0}};
            state_r <= ST_SHIFT;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end

        ST_SHIFT: begin
          if (!phase_last_s) begin
            phase_r <= phase_r + PW'(1);
          end else if (!SR_SCLK) begin
            // Sample at the end of the low half; no rising edge after the last bit.
            phase_r <= {PW{1'b0}};
            shift_r <= shift_next_s;
            if (bit_last_s) begin
              state_r <= ST_DONE;
              data_r  <= shift_next_s;
              valid_r <= 1'b1;
            end else begin
              SR_SCLK <= 1'b1;
            end
          end else begin
            phase_r <= {PW{1'b0}};
            SR_SCLK <= 1'b0;
            bit_r   <= bit_r + BW'(1);
          end
        end

        ST_DONE: begin
          phase_r <= {PW{1'b0}};
          if (CONTINUOUS != 0) begin
            state_r   <= ST_LOAD;
            SR_STROBE <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          phase_r   <= {PW{1'b0}};
          busy_r    <= 1'b0;
          SR_STROBE <= 1'b1;
          SR_SCLK   <= 1'b0;
        end
      endcase
    end
  end

endmodule
